// File: rtl/dds_pkg.sv
// Shared types, word-format constants and register map for the DDS word sequencer.
package dds_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CRST,
    S_FLSB,
    S_FMSB,
    S_PH,
    S_CRUN,
    S_DWELL,
    S_SW_LSB,
    S_SW_MSB
  } state_t;

  localparam logic [15:0] CTRL_B28   = 16'h2000;
  localparam logic [15:0] CTRL_RESET = 16'h0100;
  localparam logic [1:0]  FREQ0_SEL  = 2'b01;
  localparam logic [1:0]  FREQ1_SEL  = 2'b10;
  localparam logic [1:0]  PHASE_HDR  = 2'b11;

  localparam logic [3:0] OFF_FREQ0  = 4'd0;
  localparam logic [3:0] OFF_FREQ1  = 4'd1;
  localparam logic [3:0] OFF_FREQ2  = 4'd2;
  localparam logic [3:0] OFF_FREQ3  = 4'd3;
  localparam logic [3:0] OFF_PHASE0 = 4'd4;
  localparam logic [3:0] OFF_PHASE1 = 4'd5;
  localparam logic [3:0] OFF_CTRL   = 4'd6;
  localparam logic [3:0] OFF_STEP0  = 4'd7;
  localparam logic [3:0] OFF_STEP1  = 4'd8;
  localparam logic [3:0] OFF_DWELL0 = 4'd9;
  localparam logic [3:0] OFF_DWELL1 = 4'd10;
  localparam logic [3:0] OFF_CMD    = 4'd11;
  localparam logic [7:0] NUM_REGS   = 8'd12;

  typedef struct packed {
    logic [27:0] freq;
    logic [11:0] phase;
    logic        sweep_en;
    logic        div2;
    logic        opbiten;
    logic        mode;
    logic        fsel;
    logic [15:0] step;
    logic [15:0] dwell;
  } dds_cfg_t;

  function automatic logic is_word(input state_t st);
    return !(st inside {S_IDLE, S_DWELL});
  endfunction

  // AD9833 word for a given state; freq is passed separately because sweeps advance it.
  function automatic logic [15:0] word_of(input state_t st, input dds_cfg_t cfg,
                                          input logic [27:0] freq);
    logic [1:0]  sel;
    logic [15:0] fsel_bits;
    sel       = cfg.fsel ? FREQ1_SEL : FREQ0_SEL;
    fsel_bits = {4'b0, cfg.fsel, cfg.fsel, 10'b0};
    case (st)
      S_CRST:             word_of = CTRL_B28 | CTRL_RESET | fsel_bits;
      S_CRUN:             word_of = CTRL_B28 | fsel_bits |
                                    {10'b0, cfg.opbiten, 1'b0, cfg.div2, 1'b0, cfg.mode, 1'b0};
      S_FLSB, S_SW_LSB:   word_of = {sel, freq[13:0]};
      S_FMSB, S_SW_MSB:   word_of = {sel, freq[27:14]};
      S_PH:               word_of = {PHASE_HDR, cfg.fsel, 1'b0, cfg.phase};
      default:            word_of = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/dds_regfile.sv
// PicoBlaze port decode, shadow and active configuration registers, commit-pending flag.
module dds_regfile
  import dds_pkg::*;
#(
  parameter int BASE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       clr_pend,
  output dds_cfg_t   cfg,
  output logic       commit_pend
);

  dds_cfg_t   shadow_q;
  dds_cfg_t   active_q;
  logic [7:0] off;
  logic       hit;
  logic       commit;

  assign off    = port_id - 8'(BASE);
  assign hit    = write_strobe && (off < NUM_REGS);
  assign commit = hit && (off[3:0] == OFF_CMD);
  assign cfg    = active_q;

  // NOTE: a handful of flops, not a RAM, so every register gets the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (hit) begin
      case (off[3:0])
        OFF_FREQ0:  shadow_q.freq[7:0]   <= out_port;
        OFF_FREQ1:  shadow_q.freq[15:8]  <= out_port;
        OFF_FREQ2:  shadow_q.freq[23:16] <= out_port;
        OFF_FREQ3:  shadow_q.freq[27:24] <= out_port[3:0];
        OFF_PHASE0: shadow_q.phase[7:0]  <= out_port;
        OFF_PHASE1: shadow_q.phase[11:8] <= out_port[3:0];
        OFF_CTRL:   {shadow_q.sweep_en, shadow_q.div2, shadow_q.opbiten,
                     shadow_q.mode, shadow_q.fsel} <= out_port[4:0];
        OFF_STEP0:  shadow_q.step[7:0]   <= out_port;
        OFF_STEP1:  shadow_q.step[15:8]  <= out_port;
        OFF_DWELL0: shadow_q.dwell[7:0]  <= out_port;
        OFF_DWELL1: shadow_q.dwell[15:8] <= out_port;
        default:    ;
      endcase
    end
  end

  // NOTE: non-blocking assignment makes a same-cycle commit copy the pre-write shadow value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q    <= '0;
      commit_pend <= 1'b0;
    end else begin
      if (commit) active_q <= shadow_q;
      if (commit)        commit_pend <= 1'b1;
      else if (clr_pend) commit_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/dds_word_seq.sv
// Emits the AD9833 16-bit word sequence after each commit, with optional linear frequency sweep.
module dds_word_seq
  import dds_pkg::*;
#(
  parameter int BASE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  port_id,
  input  logic [7:0]  out_port,
  input  logic        write_strobe,
  output logic [15:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        busy
);

  dds_cfg_t    cfg;
  logic        commit_pend;
  logic        clr_pend;
  state_t      state_q, state_d;
  logic [27:0] freq_q, freq_d;
  logic [15:0] dwell_cnt_q;
  logic [15:0] dwell_last;
  logic [15:0] word_q;
  logic        valid_q;
  logic        xfer;

  dds_regfile #(.BASE(BASE)) u_regfile (
    .clk          (clk),
    .rst_n        (rst_n),
    .port_id      (port_id),
    .out_port     (out_port),
    .write_strobe (write_strobe),
    .clr_pend     (clr_pend),
    .cfg          (cfg),
    .commit_pend  (commit_pend)
  );

  assign xfer       = valid_q && word_ready;
  assign dwell_last = (cfg.dwell == 16'd0) ? 16'd0 : cfg.dwell - 16'd1;
  assign word_data  = word_q;
  assign word_valid = valid_q;
  assign busy       = (state_q != S_IDLE);

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q;
    clr_pend = 1'b0;
    case (state_q)
      S_IDLE: if (commit_pend) state_d = S_CRST;
      S_DWELL: begin
        if (commit_pend) begin
          state_d = S_CRST;
        end else if (dwell_cnt_q == dwell_last) begin
          state_d = S_SW_LSB;
          freq_d  = freq_q + {12'd0, cfg.step};
        end
      end
      default: begin
        if (xfer) begin
          if (commit_pend) begin
            state_d = S_CRST;
          end else begin
            case (state_q)
              S_CRST:   state_d = S_FLSB;
              S_FLSB:   state_d = S_FMSB;
              S_FMSB:   state_d = S_PH;
              S_PH:     state_d = S_CRUN;
              S_CRUN:   state_d = cfg.sweep_en ? S_DWELL : S_IDLE;
              S_SW_LSB: state_d = S_SW_MSB;
              S_SW_MSB: state_d = S_DWELL;
              default:  state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase
    // Each (re)entry into CRST starts a fresh sequence from the active frequency.
    if (state_d == S_CRST && (state_q != S_CRST || xfer)) begin
      clr_pend = 1'b1;
      freq_d   = cfg.freq;
    end
  end

  // The output word is registered so a commit during a stall cannot alter the word on the wire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      freq_q      <= '0;
      dwell_cnt_q <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      freq_q      <= freq_d;
      dwell_cnt_q <= (state_q == S_DWELL) ? dwell_cnt_q + 16'd1 : 16'd0;
      if (!valid_q || word_ready) begin
        word_q  <= word_of(state_d, cfg, freq_d);
        valid_q <= is_word(state_d);
      end
    end
  end

endmodule

// File: tb/tb_dds_word_seq.sv
// Scoreboard bench for dds_word_seq: expected words queued at commit, popped on each handshake.
module tb_dds_word_seq;

  localparam int BASE = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  port_id = 8'h00;
  logic [7:0]  out_port = 8'h00;
  logic        write_strobe = 1'b0;
  logic [15:0] word_data;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        busy;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          stall_cycles = 0;
  logic [15:0] exp_q[$];
  int          xfer_cyc[$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = 16'h0000;

  always #5 clk = ~clk;

  dds_word_seq #(.BASE(BASE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .port_id      (port_id),
    .out_port     (out_port),
    .write_strobe (write_strobe),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .busy         (busy)
  );

  // Monitor: compares every handshake against the scoreboard and checks stall stability.
  always @(negedge clk) begin
    logic [15:0] e;
    cyc++;
    if (rst_n) begin
      if (prev_stall) begin
        stall_cycles++;
        checks++;
        if (word_valid !== 1'b1 || word_data !== prev_data) begin
          failures++;
          $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h",
                   word_valid, word_data, prev_data);
        end
      end
      if (word_valid === 1'b1 && word_ready === 1'b1) begin
        xfer_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word: got %h, required no transfer", word_data);
        end else begin
          e = exp_q.pop_front();
          if (word_data !== e) begin
            failures++;
            $display("FAIL word_order: got %h, required %h", word_data, e);
          end
        end
      end
      prev_stall = (word_valid === 1'b1) && (word_ready !== 1'b1);
      prev_data  = word_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    port_id      = 8'(BASE + off);
    out_port     = d;
    write_strobe = 1'b1;
    step();
    write_strobe = 1'b0;
    port_id      = 8'h00;
  endtask

  task automatic program_regs(input logic [27:0] f, input logic [11:0] p, input logic [7:0] ctrl,
                              input logic [15:0] stp, input logic [15:0] dw);
    wr(0, f[7:0]);   wr(1, f[15:8]);  wr(2, f[23:16]); wr(3, {4'h0, f[27:24]});
    wr(4, p[7:0]);   wr(5, {4'h0, p[11:8]});
    wr(6, ctrl);
    wr(7, stp[7:0]); wr(8, stp[15:8]);
    wr(9, dw[7:0]);  wr(10, dw[15:8]);
  endtask

  task automatic drain(input int budget, output bit ok);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    ok = (exp_q.size() == 0);
    exp_q.delete();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (word_valid !== 1'b0 || busy !== 1'b0 || word_data !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state: valid=%b busy=%b data=%h, required 0 0 0000",
               word_valid, busy, word_data);
    end
    step(); step();
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (word_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: valid=%b busy=%b, required 0 0", word_valid, busy);
    end
  endtask

  task automatic test_words(input string name, input logic [7:0] ctrl, input logic [15:0] w[5]);
    bit ok;
    program_regs(28'h0ABCDEF, 12'h123, ctrl, 16'h0000, 16'h0000);
    word_ready = 1'b1;
    xfer_cyc.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(w[i]);
    wr(11, 8'h00);
    drain(50, ok);
    checks++;
    if (!ok || xfer_cyc.size() != 5) begin
      failures++;
      $display("FAIL %s_count: drained=%0d words=%0d, required 1 5", name, ok, xfer_cyc.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (xfer_cyc[i] - xfer_cyc[i-1] != 1) begin
          failures++;
          $display("FAIL %s_gap: word %0d gap=%0d, required 1", name, i,
                   xfer_cyc[i] - xfer_cyc[i-1]);
        end
      end
    end
    step();
    checks++;
    if (busy !== 1'b0 || word_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_end: busy=%b valid=%b, required 0 0", name, busy, word_valid);
    end
  endtask

  task automatic test_stalls();
    int n = 0;
    program_regs(28'h0ABCDEF, 12'h123, 8'h00, 16'h0000, 16'h0000);
    word_ready = 1'b0;
    xfer_cyc.delete();
    stall_cycles = 0;
    exp_q.push_back(16'h2100); exp_q.push_back(16'h4DEF); exp_q.push_back(16'h42AF);
    exp_q.push_back(16'hC123); exp_q.push_back(16'h2000);
    wr(11, 8'h00);
    while (exp_q.size() != 0 && n < 400) begin
      word_ready = (n < 4) ? 1'b0 : 1'($urandom_range(0, 1));
      step();
      n++;
    end
    word_ready = 1'b1;
    checks++;
    if (exp_q.size() != 0 || xfer_cyc.size() != 5) begin
      failures++;
      $display("FAIL stalls_count: left=%0d words=%0d, required 0 5", exp_q.size(), xfer_cyc.size());
    end
    exp_q.delete();
    checks++;
    if (stall_cycles == 0) begin
      failures++;
      $display("FAIL stalls_seen: stall cycles=%0d, required >0", stall_cycles);
    end
    repeat (2) step();
  endtask

  task automatic test_sweep();
    bit ok;
    program_regs(28'hFFFFFF0, 12'h123, 8'h10, 16'h0020, 16'h0004);
    word_ready = 1'b1;
    xfer_cyc.delete();
    exp_q.push_back(16'h2100); exp_q.push_back(16'h7FF0); exp_q.push_back(16'h7FFF);
    exp_q.push_back(16'hC123); exp_q.push_back(16'h2000);
    exp_q.push_back(16'h4010); exp_q.push_back(16'h4000);
    exp_q.push_back(16'h4030); exp_q.push_back(16'h4000);
    exp_q.push_back(16'h4050); exp_q.push_back(16'h4000);
    wr(11, 8'h00);
    drain(120, ok);
    checks++;
    if (!ok || xfer_cyc.size() != 11) begin
      failures++;
      $display("FAIL sweep_count: drained=%0d words=%0d, required 1 11", ok, xfer_cyc.size());
    end else begin
      checks++;
      if (xfer_cyc[5] - xfer_cyc[4] != 5) begin
        failures++;
        $display("FAIL sweep_first_dwell: gap=%0d, required 5", xfer_cyc[5] - xfer_cyc[4]);
      end
      checks++;
      if (xfer_cyc[7] - xfer_cyc[5] != 6 || xfer_cyc[9] - xfer_cyc[7] != 6) begin
        failures++;
        $display("FAIL sweep_period: gaps=%0d,%0d, required 6,6",
                 xfer_cyc[7] - xfer_cyc[5], xfer_cyc[9] - xfer_cyc[7]);
      end
    end
    // Commit with sweep off while dwelling: dwell aborts, new sequence ends at IDLE.
    exp_q.push_back(16'h2100); exp_q.push_back(16'h7FF0); exp_q.push_back(16'h7FFF);
    exp_q.push_back(16'hC123); exp_q.push_back(16'h2000);
    wr(6, 8'h00);
    wr(11, 8'h00);
    drain(50, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL sweep_abort: sequence after dwell commit incomplete, required 5 words");
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL sweep_stop_idle: busy=%b, required 0", busy);
    end
    repeat (10) step();
  endtask

  task automatic test_commit_fmsb();
    bit ok;
    int n = 0;
    program_regs(28'h0ABCDEF, 12'h123, 8'h00, 16'h0000, 16'h0000);
    word_ready = 1'b0;
    exp_q.push_back(16'h2100); exp_q.push_back(16'h4DEF); exp_q.push_back(16'h42AF);
    wr(11, 8'h00);
    while (!(word_valid === 1'b1 && word_data === 16'h2100) && n < 20) begin
      step();
      n++;
    end
    word_ready = 1'b1;
    step(); step();
    word_ready = 1'b0;
    checks++;
    if (word_valid !== 1'b1 || word_data !== 16'h42AF) begin
      failures++;
      $display("FAIL fmsb_reached: valid=%b data=%h, required 1 42af", word_valid, word_data);
    end
    wr(4, 8'h56);
    wr(5, 8'h04);
    exp_q.push_back(16'h2100); exp_q.push_back(16'h4DEF); exp_q.push_back(16'h42AF);
    exp_q.push_back(16'hC456); exp_q.push_back(16'h2000);
    wr(11, 8'h00);
    repeat (3) step();
    word_ready = 1'b1;
    drain(50, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL fmsb_commit: words left undelivered, required all 8 transferred");
    end
    repeat (2) step();
  endtask

  task automatic test_async_reset();
    bit ok;
    int n = 0;
    program_regs(28'h0ABCDEF, 12'h123, 8'h00, 16'h0000, 16'h0000);
    word_ready = 1'b0;
    wr(11, 8'h00);
    while (word_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (word_valid !== 1'b0 || busy !== 1'b0 || word_data !== 16'h0000) begin
      failures++;
      $display("FAIL async_reset: valid=%b busy=%b data=%h, required 0 0 0000",
               word_valid, busy, word_data);
    end
    exp_q.delete();
    step();
    rst_n = 1'b1;
    word_ready = 1'b1;
    xfer_cyc.delete();
    repeat (20) step();
    wr(12, 8'hFF);
    wr(-1, 8'hFF);
    repeat (10) step();
    checks++;
    if (xfer_cyc.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_quiet: words=%0d busy=%b, required 0 0", xfer_cyc.size(), busy);
    end
    // Shadow registers were cleared by reset, so this commit emits all-zero settings.
    exp_q.push_back(16'h2100); exp_q.push_back(16'h4000); exp_q.push_back(16'h4000);
    exp_q.push_back(16'hC000); exp_q.push_back(16'h2000);
    wr(11, 8'h00);
    drain(50, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL post_reset_commit: sequence incomplete, required 5 words");
    end
    repeat (2) step();
  endtask

  initial begin
    logic [15:0] w1[5];
    logic [15:0] w2[5];
    w1 = '{16'h2100, 16'h4DEF, 16'h42AF, 16'hC123, 16'h2000};
    w2 = '{16'h2D00, 16'h8DEF, 16'h82AF, 16'hE123, 16'h2C02};
    test_reset();
    test_words("basic", 8'h00, w1);
    test_words("fsel_mode", 8'h03, w2);
    test_stalls();
    test_sweep();
    test_commit_fmsb();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
